// File: rtl/ga_pkg.sv
// rtl/ga_pkg.sv - shared GA datapath types and defaults
package ga_pkg;
  localparam int DEFAULT_FITNESS_WIDTH = 27;

  typedef logic [DEFAULT_FITNESS_WIDTH-1:0] fitness_t;

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } sel_state_e;
endpackage

// File: rtl/fitness_compare.sv
// rtl/fitness_compare.sv - combinational win rule; ties go to the candidate
module fitness_compare
  import ga_pkg::*;
#(
  parameter int FITNESS_WIDTH = DEFAULT_FITNESS_WIDTH,
  parameter bit MAXIMIZE      = 1'b0
) (
  input  logic [FITNESS_WIDTH-1:0] best_fitness,
  input  logic [FITNESS_WIDTH-1:0] cand_fitness,
  output logic                     cand_wins
);
  assign cand_wins = MAXIMIZE ? (cand_fitness >= best_fitness)
                              : (best_fitness >= cand_fitness);
endmodule

// File: rtl/tournament_selection.sv
// rtl/tournament_selection.sv - streaming K-way tournament selector
module tournament_selection
  import ga_pkg::*;
#(
  parameter int FITNESS_WIDTH   = DEFAULT_FITNESS_WIDTH,
  parameter int INDEX_WIDTH     = 8,
  parameter int TOURNAMENT_SIZE = 4,
  parameter bit MAXIMIZE        = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FITNESS_WIDTH-1:0] in_fitness,
  input  logic [INDEX_WIDTH-1:0]   in_index,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INDEX_WIDTH-1:0]   out_index,
  output logic [FITNESS_WIDTH-1:0] out_fitness
);
  localparam int CW = $clog2(TOURNAMENT_SIZE);
  localparam logic [CW-1:0] LAST = CW'(TOURNAMENT_SIZE - 1);

  sel_state_e               state;
  logic [CW-1:0]            count;
  logic [FITNESS_WIDTH-1:0] best_fitness;
  logic [INDEX_WIDTH-1:0]   best_index;
  logic                     cand_wins;
  logic                     take;
  logic                     accept;
  logic [FITNESS_WIDTH-1:0] next_fitness;
  logic [INDEX_WIDTH-1:0]   next_index;

  fitness_compare #(
    .FITNESS_WIDTH(FITNESS_WIDTH),
    .MAXIMIZE     (MAXIMIZE)
  ) u_compare (
    .best_fitness(best_fitness),
    .cand_fitness(in_fitness),
    .cand_wins   (cand_wins)
  );

  assign in_ready = (state == COLLECT);
  assign accept   = in_valid & in_ready;
  // The first candidate of a tournament seeds the running winner regardless of the compare.
  assign take         = (count == '0) | cand_wins;
  assign next_fitness = take ? in_fitness : best_fitness;
  assign next_index   = take ? in_index : best_index;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= COLLECT;
      count        <= '0;
      out_valid    <= 1'b0;
      out_index    <= '0;
      out_fitness  <= '0;
      best_fitness <= '0;
      best_index   <= '0;
    end else if (flush) begin
      state     <= COLLECT;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (count == LAST) begin
              state       <= DONE;
              count       <= '0;
              out_valid   <= 1'b1;
              out_index   <= next_index;
              out_fitness <= next_fitness;
            end else begin
              count        <= count + CW'(1);
              best_fitness <= next_fitness;
              best_index   <= next_index;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= COLLECT;
            out_valid <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule
